bus_responder: RTL
==================

Name: bus_responder

Overview:
- Target side of the CPU memory bus. It decodes the CPU address/WE and answers with read data (DI) and RDY wait-state control.
- It contains an internal synchronous RAM and a req/ack bridge to one external I/O page.
- It sits between the cpu core and board peripherals, as the counterpart of the CPU's initiator interface.

Parameters:
- RAM_AW, 15, RAM address width. RAM occupies 0x0000 up to 2^RAM_AW-1; max 15.
- IO_PAGE, 8'hD0, high address byte of the 256-byte I/O page.
- TIMEOUT, 16, maximum cycles to wait for io_ack when BUS_TIMEOUT_EN is defined; range 2..255.

Ports:
- clk  in  1  CPU clock
- RST  in  1  synchronous active-high reset
- AD  in  16  CPU address (combinatorial from CPU, held stable while RDY=0)
- DO  in  8  CPU write data
- WE  in  1  CPU write enable
- DI  out  8  read data to CPU (registered)
- RDY  out  1  1 = access completes this cycle; 0 = CPU stalls
- io_addr  out  8  latched low address byte for I/O access
- io_wdata  out  8  latched write data
- io_we  out  1  latched direction of the pending I/O access
- io_req  out  1  I/O request, held until ack or timeout
- io_ack  in  1  peripheral completion strobe (1 cycle)
- io_rdata  in  8  peripheral read data, valid with io_ack
- bus_err  out  1  sticky timeout flag; cleared only by RST

Behaviour:
- Reset (RST=1 at posedge) forces the following, abandoning any pending I/O access without waiting for ack:
  - DI=8'h00, RDY=1, io_req=0, io_we=0, io_addr=0, io_wdata=0, bus_err=0, state=IDLE.
  - RAM contents are not cleared.
- Address decode, evaluated only in IDLE with RDY=1:
  - RAM when AD < 2^RAM_AW.
  - IO when AD[15:8]==IO_PAGE.
  - Everything else is unmapped.
  - IO wins if it overlaps RAM.
- RAM access, zero wait:
  - Write: at the posedge where WE=1, mem[AD]<=DO.
  - Read: DI<=mem[AD] at the same posedge, so data is valid in the following cycle (1-cycle read latency).
  - A write does not update DI; DI holds its previous value.
- Unmapped access: reads set DI<=8'hFF; writes are ignored; RDY stays 1.
- State machine IDLE -> IO_WAIT -> IO_DONE -> IDLE:
  - IDLE with IO decode: latch io_addr<=AD[7:0], io_wdata<=DO, io_we<=WE; set io_req<=1 and RDY<=0; go to IO_WAIT.
  - IO_WAIT: hold io_req=1 and RDY=0.
    - On io_ack=1: io_req<=0, DI<=io_rdata if io_we=0 (unchanged otherwise), RDY<=1, go to IO_DONE.
  - IO_DONE: one cycle with RDY=1 in which the CPU consumes DI. Return to IDLE without re-decoding the held AD; decoding of the next address resumes in IDLE.
- Minimum I/O latency: request posedge, ack at the earliest on the next posedge, giving 1 RDY-low cycle; an ack arriving k cycles later gives k RDY-low cycles.
- io_ack outside IO_WAIT is ignored.
- io_rdata is sampled only on the ack cycle.
- Back-to-back I/O accesses are separated by the IO_DONE cycle, so io_req is low for at least one cycle between requests.
- RDY is a registered output with no combinational path from AD.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to IO_WAIT and increments each IO_WAIT cycle.
  - When it reaches TIMEOUT-1 without ack: io_req<=0, bus_err<=1 (sticky), DI<=8'hFF for reads, RDY<=1, go to IO_DONE.
  - If io_ack and the timeout coincide, ack wins and bus_err is unchanged.
- Undefined: no counter; IO_WAIT waits indefinitely; bus_err is tied 0.

Test Plan:
- RAM write/read:
  - WE=1, AD=0x0200, DO=0x5A; next cycle AD=0x0200, WE=0 -> DI=0x5A one cycle later, RDY stays 1 throughout.
  - The first read of 0x0201 after reset returns whatever RAM holds; DI is 0x00 only before any read.
- Unmapped read: AD=0xE000, WE=0 -> DI=0xFF next cycle, RDY=1; an unmapped write leaves RAM and DI unchanged.
- I/O read:
  - Stimulus: AD=0xD012, WE=0; peripheral asserts io_ack with io_rdata=0xC3 three cycles after io_req rises.
  - Required: io_addr=0x12, io_we=0, io_req high for 3 cycles, RDY low for 3 cycles, then DI=0xC3 with RDY=1.
- I/O write: AD=0xD005, DO=0x77, WE=1, ack on the next cycle -> io_wdata=0x77, io_we=1, 1 RDY-low cycle, DI unchanged.
- Reset mid-access: RST=1 during IO_WAIT -> next cycle io_req=0, RDY=1, DI=0x00; a late io_ack afterwards is ignored.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT=16): no ack on an I/O read -> io_req drops after 16 IO_WAIT cycles, DI=0xFF, RDY=1, bus_err=1 and stays 1 until RST.

Source files
------------

// File: rtl/bus_responder.sv
// bus_responder: CPU bus target with an internal synchronous RAM and a req/ack bridge to one I/O page.
// Optional feature macro BUS_TIMEOUT_EN: bounded io_ack wait with a sticky bus_err flag.
//
// state   | meaning
// IDLE    | decode AD every cycle; RAM and unmapped accesses complete with zero wait
// IO_WAIT | io_req held high, CPU stalled (RDY=0) until io_ack or timeout
// IO_DONE | single RDY=1 cycle in which the CPU consumes DI; no decode
module bus_responder #(
    parameter int unsigned RAM_AW  = 15,
    parameter logic [7:0]  IO_PAGE = 8'hD0,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] AD,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_we,
    output logic        io_req,
    input  logic        io_ack,
    input  logic [7:0]  io_rdata,
    output logic        bus_err
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    if (RAM_AW < 1 || RAM_AW > 15) begin : g_bad_aw
        $error("bus_responder: RAM_AW must be 1..15");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_responder: TIMEOUT must be 2..255");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IO_WAIT = 2'd1,
        IO_DONE = 2'd2
    } state_t;

    state_t state;

    logic [7:0]        mem [RAM_DEPTH];
    logic              hit_io;
    logic              hit_ram;
    logic [RAM_AW-1:0] ram_addr;

    // The I/O page takes priority over any RAM overlap.
    assign hit_io   = (AD[15:8] == IO_PAGE);
    assign hit_ram  = !hit_io && ((AD >> RAM_AW) == 16'd0);
    assign ram_addr = AD[RAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (!RST && state == IDLE && hit_ram && WE) begin
            mem[ram_addr] <= DO;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= IDLE;
            DI       <= 8'h00;
            RDY      <= 1'b1;
            io_req   <= 1'b0;
            io_we    <= 1'b0;
            io_addr  <= 8'h00;
            io_wdata <= 8'h00;
`ifdef BUS_TIMEOUT_EN
            wait_cnt <= 8'd0;
            bus_err  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hit_io) begin
                        io_addr  <= AD[7:0];
                        io_wdata <= DO;
                        io_we    <= WE;
                        io_req   <= 1'b1;
                        RDY      <= 1'b0;
                        state    <= IO_WAIT;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt <= 8'd0;
`endif
                    end else if (hit_ram) begin
                        if (!WE) begin
                            DI <= mem[ram_addr];
                        end
                    end else if (!WE) begin
                        DI <= 8'hFF;
                    end
                end

                IO_WAIT: begin
                    if (io_ack) begin
                        io_req <= 1'b0;
                        RDY    <= 1'b1;
                        state  <= IO_DONE;
                        if (!io_we) begin
                            DI <= io_rdata;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        io_req  <= 1'b0;
                        bus_err <= 1'b1;
                        RDY     <= 1'b1;
                        state   <= IO_DONE;
                        if (!io_we) begin
                            DI <= 8'hFF;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end

                IO_DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    RDY    <= 1'b1;
                    io_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
